// File: rtl/ticket_entry.sv
// Digit-entry front end: packs NDIG BCD/hex digits MSD-first and offers the ticket over valid/ready.
// Optional feature: define BCD_CHECK_EN to reject digits above 9.
module ticket_entry #(
    parameter int NDIG = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          num,
    input  logic                insere,
    input  logic                fim,
    input  logic                fim_jogo,
    input  logic                tkt_ready,
    output logic                tkt_valid,
    output logic [4*NDIG-1:0]   tkt,
    output logic [2:0]          cnt,
    output logic                busy,
    output logic                err,
    output logic                ovf
);

    localparam logic [2:0] FULL = 3'(NDIG);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        OFFER
    } state_t;

    state_t            state, state_n;
    logic [4*NDIG-1:0] tkt_n;
    logic [2:0]        cnt_n;
    logic              err_n;
    logic              ovf_n;
    logic              digit_ok;

`ifdef BCD_CHECK_EN
    assign digit_ok = (num <= 4'd9);
`else
    assign digit_ok = 1'b1;
`endif

    // Priority inside every state: fim_jogo > fim > insere.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_n = state;
        tkt_n   = tkt;
        cnt_n   = cnt;
        ovf_n   = ovf;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fim_jogo) begin
                    if (fim) begin
                        err_n = 1'b1;
                    end else if (insere) begin
                        if (digit_ok) begin
                            tkt_n                 = '0;
                            tkt_n[4*NDIG-1 -: 4]  = num;
                            cnt_n                 = 3'd1;
                            state_n               = COLLECT;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
            end
            COLLECT: begin
                if (fim_jogo) begin
                    cnt_n   = '0;
                    tkt_n   = '0;
                    ovf_n   = 1'b0;
                    state_n = IDLE;
                end else if (fim) begin
                    if (cnt == FULL) begin
                        state_n = OFFER;
                    end else begin
                        err_n   = 1'b1;
                        cnt_n   = '0;
                        tkt_n   = '0;
                        state_n = IDLE;
                    end
                end else if (insere) begin
                    if (!digit_ok) begin
                        err_n = 1'b1;
                    end else if (cnt == FULL) begin
                        ovf_n = 1'b1;
                    end else begin
                        for (int i = 0; i < NDIG; i++) begin
                            if (cnt == 3'(i)) tkt_n[4*(NDIG-1-i) +: 4] = num;
                        end
                        cnt_n = cnt + 3'd1;
                    end
                end
            end
            OFFER: begin
                // tkt is deliberately left intact after the transfer.
                if (tkt_ready) begin
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // All outputs are registered; valid and busy are decoded from the next state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state     <= IDLE;
            tkt       <= '0;
            tkt_valid <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_n;
            tkt       <= tkt_n;
            tkt_valid <= (state_n == OFFER);
            cnt       <= cnt_n;
            busy      <= (state_n != IDLE);
            err       <= err_n;
            ovf       <= ovf_n;
        end
    end

endmodule

// File: tb/tb_ticket_entry.sv
// Directed self-checking bench for ticket_entry (NDIG=5); expectations follow BCD_CHECK_EN if defined.
module tb_ticket_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  num;
    logic        insere;
    logic        fim;
    logic        fim_jogo;
    logic        tkt_ready;
    logic        tkt_valid;
    logic [19:0] tkt;
    logic [2:0]  cnt;
    logic        busy;
    logic        err;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    ticket_entry #(.NDIG(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .num       (num),
        .insere    (insere),
        .fim       (fim),
        .fim_jogo  (fim_jogo),
        .tkt_ready (tkt_ready),
        .tkt_valid (tkt_valid),
        .tkt       (tkt),
        .cnt       (cnt),
        .busy      (busy),
        .err       (err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then observed 1 ns after it and new inputs applied.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [3:0] d);
        insere = 1'b1;
        num    = d;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; num = '0; insere = 0; fim = 0; fim_jogo = 0; tkt_ready = 0;
        cyc(); cyc();
        reset = 1'b0;
        checks++; if (tkt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", tkt_valid); end
        checks++; if (tkt !== 20'h0) begin failures++; $display("FAIL reset_tkt: got %h want 00000", tkt); end
        checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL reset_flags: err=%b ovf=%b want 0 0", err, ovf); end
        fim = 1'b1; cyc(); fim = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL idle_fim: err=%b busy=%b want 1 0", err, busy); end
    endtask

    task automatic test_basic();
        enter(4); enter(7); enter(0); enter(1); enter(0); insere = 0;
        checks++; if (cnt !== 3'd5 || busy !== 1'b1) begin failures++; $display("FAIL basic_cnt: cnt=%0d busy=%b want 5 1", cnt, busy); end
        fim = 1; tkt_ready = 1; cyc(); fim = 0;
        checks++; if (tkt_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b want 1", tkt_valid); end
        checks++; if (tkt !== 20'h47010) begin failures++; $display("FAIL basic_tkt: got %h want 47010", tkt); end
        cyc(); tkt_ready = 0;
        checks++; if (tkt_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle: valid=%b want 0", tkt_valid); end
        checks++; if (cnt !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL basic_done: cnt=%0d busy=%b want 0 0", cnt, busy); end
        checks++; if (tkt !== 20'h47010) begin failures++; $display("FAIL basic_tkt_kept: got %h want 47010", tkt); end
    endtask

    task automatic test_backpressure();
        tkt_ready = 0;
        enter(6); enter(7); enter(0); enter(3); enter(9); insere = 0;
        fim = 1; cyc(); fim = 0;
        checks++; if (tkt_valid !== 1'b1 || tkt !== 20'h67039) begin failures++; $display("FAIL bp_offer: valid=%b tkt=%h want 1 67039", tkt_valid, tkt); end
        for (int i = 0; i < 3; i++) begin
            insere = (i != 1); num = 4'(i + 1); fim = (i == 1);
            cyc();
            checks++; if (tkt_valid !== 1'b1 || tkt !== 20'h67039 || cnt !== 3'd5) begin
                failures++; $display("FAIL bp_hold%0d: valid=%b tkt=%h cnt=%0d want 1 67039 5", i, tkt_valid, tkt, cnt);
            end
        end
        insere = 0; fim = 0;
        checks++; if (ovf !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL bp_ignored: ovf=%b err=%b want 0 0", ovf, err); end
        tkt_ready = 1; cyc(); tkt_ready = 0;
        checks++; if (tkt_valid !== 1'b0 || cnt !== 3'd0) begin failures++; $display("FAIL bp_xfer: valid=%b cnt=%0d want 0 0", tkt_valid, cnt); end
    endtask

    task automatic test_short_abort();
        enter(2); enter(3); enter(1); insere = 0;
        fim = 1; cyc(); fim = 0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL short_err: got %b want 1", err); end
        checks++; if (tkt_valid !== 1'b0 || cnt !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL short_state: valid=%b cnt=%0d busy=%b want 0 0 0", tkt_valid, cnt, busy);
        end
        checks++; if (tkt !== 20'h0) begin failures++; $display("FAIL short_tkt: got %h want 00000", tkt); end
        cyc();
        checks++; if (err !== 1'b0 || tkt_valid !== 1'b0) begin failures++; $display("FAIL short_pulse: err=%b valid=%b want 0 0", err, tkt_valid); end
        enter(4); enter(9); insere = 0;
        checks++; if (cnt !== 3'd2 || tkt !== 20'h49000) begin failures++; $display("FAIL abort_pre: cnt=%0d tkt=%h want 2 49000", cnt, tkt); end
        fim_jogo = 1; cyc(); fim_jogo = 0;
        checks++; if (cnt !== 3'd0 || busy !== 1'b0 || tkt !== 20'h0) begin
            failures++; $display("FAIL abort: cnt=%0d busy=%b tkt=%h want 0 0 00000", cnt, busy, tkt);
        end
        enter(1); enter(2); insere = 0;
        fim_jogo = 1; fim = 1; cyc(); fim_jogo = 0; fim = 0;
        checks++; if (err !== 1'b0 || cnt !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_prio: err=%b cnt=%0d busy=%b want 0 0 0", err, cnt, busy);
        end
    endtask

    task automatic test_overflow();
        enter(4); enter(7); enter(0); enter(2); enter(9);
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", ovf); end
        enter(5); insere = 0;
        checks++; if (ovf !== 1'b1 || cnt !== 3'd5) begin failures++; $display("FAIL ovf_set: ovf=%b cnt=%0d want 1 5", ovf, cnt); end
        fim = 1; tkt_ready = 1; cyc(); fim = 0;
        checks++; if (tkt_valid !== 1'b1 || tkt !== 20'h47029 || ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_offer: valid=%b tkt=%h ovf=%b want 1 47029 1", tkt_valid, tkt, ovf);
        end
        cyc(); tkt_ready = 0;
        checks++; if (tkt_valid !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear: valid=%b ovf=%b want 0 0", tkt_valid, ovf); end
    endtask

    task automatic test_bcd();
        logic [19:0] exp_tkt;
        logic        exp_ovf;
        enter(1); enter(7); enter(4'hA);
`ifdef BCD_CHECK_EN
        checks++; if (err !== 1'b1 || cnt !== 3'd2) begin failures++; $display("FAIL bcd_reject: err=%b cnt=%0d want 1 2", err, cnt); end
        exp_tkt = 20'h17011; exp_ovf = 1'b0;
`else
        checks++; if (err !== 1'b0 || cnt !== 3'd3) begin failures++; $display("FAIL bcd_accept: err=%b cnt=%0d want 0 3", err, cnt); end
        exp_tkt = 20'h17A01; exp_ovf = 1'b1;
`endif
        enter(0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL bcd_pulse: err=%b want 0", err); end
        enter(1); enter(1); insere = 0;
        fim = 1; tkt_ready = 1; cyc(); fim = 0;
        checks++; if (tkt_valid !== 1'b1 || tkt !== exp_tkt || ovf !== exp_ovf) begin
            failures++; $display("FAIL bcd_offer: valid=%b tkt=%h ovf=%b want 1 %h %b", tkt_valid, tkt, ovf, exp_tkt, exp_ovf);
        end
        cyc(); tkt_ready = 0;
    endtask

    task automatic test_reset_priority();
        enter(1); enter(2); enter(3); enter(4); enter(5); insere = 0;
        fim = 1; cyc(); fim = 0;
        checks++; if (tkt_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_offer: valid=%b want 1", tkt_valid); end
        reset = 1; cyc(); reset = 0;
        checks++; if (tkt_valid !== 1'b0 || tkt !== 20'h0 || cnt !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_offer: valid=%b tkt=%h cnt=%0d busy=%b want 0 00000 0 0", tkt_valid, tkt, cnt, busy);
        end
        enter(8); enter(8); enter(8); enter(8); enter(8);
        num = 3; insere = 1; fim = 1; cyc(); insere = 0; fim = 0;
        checks++; if (tkt_valid !== 1'b1 || ovf !== 1'b0 || tkt !== 20'h88888) begin
            failures++; $display("FAIL prio_fim_insere: valid=%b ovf=%b tkt=%h want 1 0 88888", tkt_valid, ovf, tkt);
        end
        tkt_ready = 1; cyc(); tkt_ready = 0;
        checks++; if (tkt_valid !== 1'b0) begin failures++; $display("FAIL prio_xfer: valid=%b want 0", tkt_valid); end
    endtask

    task automatic test_back_to_back();
        enter(1); enter(2); enter(3); enter(4); enter(5); insere = 0;
        fim = 1; tkt_ready = 1; cyc(); fim = 0;
        checks++; if (tkt_valid !== 1'b1 || tkt !== 20'h12345) begin failures++; $display("FAIL b2b_first: valid=%b tkt=%h want 1 12345", tkt_valid, tkt); end
        cyc();
        enter(9);
        checks++; if (cnt !== 3'd1 || busy !== 1'b1 || tkt[19:16] !== 4'h9) begin
            failures++; $display("FAIL b2b_capture: cnt=%0d busy=%b msd=%h want 1 1 9", cnt, busy, tkt[19:16]);
        end
        enter(8); enter(7); enter(6); enter(5); insere = 0;
        fim = 1; cyc(); fim = 0;
        checks++; if (tkt_valid !== 1'b1 || tkt !== 20'h98765) begin failures++; $display("FAIL b2b_second: valid=%b tkt=%h want 1 98765", tkt_valid, tkt); end
        cyc(); tkt_ready = 0;
        checks++; if (tkt_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_done: valid=%b busy=%b want 0 0", tkt_valid, busy); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_short_abort();
        test_overflow();
        test_bcd();
        test_reset_priority();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
